// File: rtl/vend_coin_arbiter_pkg.sv
// vend_pkg: shared coin/state types and balance constants for the coin arbiter.
// Balances are kept in 5-unit steps, so BAL10 = 2 and a vend completes at 3 units.
package vend_pkg;
   typedef enum logic {COIN5 = 1'b0, COIN10 = 1'b1} coin_t;
   typedef enum logic [1:0] {ACCEPT, HOLD, CHECK} arb_state_t;
   localparam logic [1:0] BAL0 = 2'd0;
   localparam logic [1:0] BAL5 = 2'd1;
   localparam logic [1:0] BAL10 = 2'd2;
   localparam int VEND_PRICE = 15;
   localparam logic [2:0] VEND_UNITS = 3'(VEND_PRICE / 5);
   localparam logic [2:0] CHANGE_UNITS = VEND_UNITS + 3'd1;
   function automatic logic [2:0] coin_units(coin_t c);
      return c == COIN10 ? 3'd2 : 3'd1;
   endfunction
endpackage

// File: rtl/vend_coin_arbiter_if.sv
// vend_coin_arbiter_if: coin slots, FSM pulse/response and status signals.
// Statistics counters exist only when VEND_COIN_ARB_STATS_EN is defined.
interface vend_coin_arbiter_if;
   logic a_valid, a_coin, a_ready;
   logic b_valid, b_coin, b_ready;
   logic rs5, rs10, item1, rs5out, err;
`ifdef VEND_COIN_ARB_STATS_EN
   logic [15:0] vend_count, change_count;
   modport master(output a_valid, a_coin, b_valid, b_coin, item1, rs5out,
                  input a_ready, b_ready, rs5, rs10, err, vend_count, change_count);
   modport slave(input a_valid, a_coin, b_valid, b_coin, item1, rs5out,
                 output a_ready, b_ready, rs5, rs10, err, vend_count, change_count);
`else
   modport master(output a_valid, a_coin, b_valid, b_coin, item1, rs5out,
                  input a_ready, b_ready, rs5, rs10, err);
   modport slave(input a_valid, a_coin, b_valid, b_coin, item1, rs5out,
                 output a_ready, b_ready, rs5, rs10, err);
`endif
endinterface

// File: rtl/vend_coin_arbiter_fifo.sv
// vend_coin_fifo: 1-bit coin FIFO; pointers carry an extra wrap bit for full/empty.
module vend_coin_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [DEPTH-1:0] mem;
   logic [AW:0] wp, rp;
   assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
   assign empty = wp == rp;
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && !full) wp <= wp + (AW+1)'(1);
         if (pop && !empty) rp <= rp + (AW+1)'(1);
      end
   always_ff @(posedge clk)
      if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/vend_coin_arbiter.sv
// vend_coin_arbiter: round-robin coin serialiser with FSM balance mirror and response check.
// Define VEND_COIN_ARB_STATS_EN to add vend_count/change_count.
module vend_coin_arbiter
   import vend_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic reset,
   vend_coin_arbiter_if.slave bus
);
   arb_state_t state;
   logic ptr, exp_change, rs5, rs10, err;
   logic [1:0] bal;
   logic a_full, a_empty, a_dout, b_full, b_empty, b_dout;
   logic grant_a, grant_b, pop, done;
   coin_t coin;
   logic [2:0] sum;
   vend_coin_fifo #(.DEPTH(DEPTH)) u_fifo_a (
      .clk(clk), .reset(reset), .push(bus.a_valid), .pop(grant_a), .din(bus.a_coin),
      .dout(a_dout), .full(a_full), .empty(a_empty)
   );
   vend_coin_fifo #(.DEPTH(DEPTH)) u_fifo_b (
      .clk(clk), .reset(reset), .push(bus.b_valid), .pop(grant_b), .din(bus.b_coin),
      .dout(b_dout), .full(b_full), .empty(b_empty)
   );
   // ptr = 0 favours slot A on a tie; the winner always hands priority to the other slot
   always_comb begin
      grant_a = state != HOLD && !a_empty && (b_empty || !ptr);
      grant_b = state != HOLD && !b_empty && (a_empty || ptr);
      pop = grant_a || grant_b;
      coin = coin_t'(grant_a ? a_dout : b_dout);
      sum = {1'b0, bal} + coin_units(coin);
      done = pop && sum >= VEND_UNITS;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= ACCEPT;
         ptr <= 1'b0;
         bal <= BAL0;
         exp_change <= 1'b0;
         rs5 <= 1'b0;
         rs10 <= 1'b0;
         err <= 1'b0;
      end else begin
         rs5 <= pop && coin == COIN5;
         rs10 <= pop && coin == COIN10;
         err <= err || (state == CHECK && (!bus.item1 || bus.rs5out != exp_change));
         if (pop) begin
            ptr <= grant_a;
            bal <= done ? BAL0 : sum[1:0];
         end
         if (done) exp_change <= sum == CHANGE_UNITS;
         state <= done ? HOLD : state == HOLD ? CHECK : ACCEPT;
      end
   assign bus.a_ready = !a_full;
   assign bus.b_ready = !b_full;
   assign bus.rs5 = rs5;
   assign bus.rs10 = rs10;
   assign bus.err = err;
`ifdef VEND_COIN_ARB_STATS_EN
   logic [15:0] vend_count, change_count;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         vend_count <= '0;
         change_count <= '0;
      end else if (state == CHECK) begin
         vend_count <= vend_count + 16'd1;
         if (exp_change) change_count <= change_count + 16'd1;
      end
   assign bus.vend_count = vend_count;
   assign bus.change_count = change_count;
`endif
endmodule
